ram_sdp_clr: RTL and testbench

RAM_SDP_CLR -- requirements
Module: ram_sdp_clr

---
 rtl/ram_pkg.sv | 14 +
 rtl/ram_clear_seq.sv | 49 ++++
 rtl/ram_sdp_clr.sv | 103 ++++++++++
 tb/tb_ram_sdp_clr.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared types and constants for the simple dual-port RAM with a power-up clear.
`timescale 1ns/1ps
package ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } clr_state_e;

  // Values for the RDW_NEW parameter.
  localparam int RDW_MODE_OLD = 0;
  localparam int RDW_MODE_NEW = 1;

endpackage

// File: rtl/ram_clear_seq.sv
// Clear sequencer: walks every address once after reset, writing zero, then parks in READY.
`timescale 1ns/1ps
module ram_clear_seq
  import ram_pkg::*;
#(
  parameter int ADDR_W         = 6,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr,
  output clr_state_e        dbg_state
);

  localparam clr_state_e RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      // Counter wraps back to 0 on the final clear write, ready for any later reset.
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == {ADDR_W{1'b1}}) begin
        state_d = ST_READY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET_STATE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy      = (state_q == ST_CLEAR);
  assign clr_we    = (state_q == ST_CLEAR);
  assign clr_addr  = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: rtl/ram_sdp_clr.sv
// Simple dual-port RAM (one write port with byte enables, one registered read port)
// with an optional zero-fill sequence after reset.
`timescale 1ns/1ps
module ram_sdp_clr
  import ram_pkg::*;
#(
  parameter int DATA_W         = 8,
  parameter int ADDR_W         = 6,
  parameter int RDW_NEW        = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_be,
  input  logic                  rd_en,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  rd_valid,
  output logic                  busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / 8;

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  clr_state_e        clr_state;

  ram_clear_seq #(
    .ADDR_W        (ADDR_W),
    .CLEAR_ON_RESET(CLEAR_ON_RESET)
  ) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .dbg_state(clr_state)
  );

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q;
  logic              ready;
  logic              wr_fire;
  logic              rd_fire;
  logic [DATA_W-1:0] rd_old;
  logic [DATA_W-1:0] rd_merged;

  assign ready   = (clr_state == ST_READY);
  assign wr_fire = wr_en & ready;
  assign rd_fire = rd_en & ready;
  assign rd_old  = mem_q[rd_addr];

  // Read-during-write bypass: the stored word with the written lanes overlaid.
  always_comb begin
    rd_merged = rd_old;
    for (int i = 0; i < LANES; i++) begin
      if (wr_be[i]) begin
        rd_merged[8*i +: 8] = wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    rd_data_d = rd_old;
    if ((RDW_NEW == RDW_MODE_NEW) && wr_fire && (wr_addr == rd_addr)) begin
      rd_data_d = rd_merged;
    end
  end

  // Memory has no reset; only the clear sequence zeroes it.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (wr_fire) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_be[i]) begin
          mem_q[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_data_q <= rd_data_d;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_ram_sdp_clr.sv
// Bench for ram_sdp_clr: three builds (new-data RDW, old-data RDW, no clear) share one stimulus stream.
`timescale 1ns/1ps
module tb_ram_sdp_clr;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [1:0]    wr_be;
  logic          rd_en;
  logic [AW-1:0] rd_addr;

  logic [DW-1:0] rd_data_n, rd_data_o, rd_data_c;
  logic          rd_valid_n, rd_valid_o, rd_valid_c;
  logic          busy_n, busy_o, busy_c;

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(1), .CLEAR_ON_RESET(1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_valid(rd_valid_n), .busy(busy_n));

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(0), .CLEAR_ON_RESET(1)) dut_old (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_o),
    .rd_valid(rd_valid_o), .busy(busy_o));

  ram_sdp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_NEW(1), .CLEAR_ON_RESET(0)) dut_nc (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_be(wr_be), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data_c),
    .rd_valid(rd_valid_c), .busy(busy_c));

  int n_checks = 0;
  int n_pass   = 0;
  int busy_seen;
  logic [DW-1:0] exp_q[$];

  // Reference model for the clearing builds (shared memory image)
  logic [DW-1:0] m_mem [DEPTH];
  logic          m_busy;
  int            m_cnt;
  logic [DW-1:0] m_rd_new, m_rd_old;
  logic          m_vld;
  // Reference model for the no-clear build; contents unknown until written, tracked per byte
  logic [DW-1:0] c_mem [DEPTH];
  logic [1:0]    c_known [DEPTH];
  logic [DW-1:0] c_rd;
  logic [1:0]    c_rd_known;
  logic          c_vld;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] o, input logic [DW-1:0] d,
                                          input logic [1:0] be);
    logic [DW-1:0] r;
    r = o;
    for (int i = 0; i < 2; i++) if (be[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic logic [DW-1:0] lane_mask(input logic [1:0] kn);
    return {{8{kn[1]}}, {8{kn[0]}}};
  endfunction

  task automatic model_reset();
    m_busy = 1'b1; m_cnt = 0; m_rd_new = '0; m_rd_old = '0; m_vld = 1'b0;
    c_rd = '0; c_rd_known = 2'b11; c_vld = 1'b0;
  endtask

  task automatic model_edge();
    logic coll;
    coll = wr_en && (wr_addr == rd_addr);
    if (m_busy) begin
      m_mem[m_cnt] = '0;
      m_cnt++;
      if (m_cnt == DEPTH) begin m_busy = 1'b0; m_cnt = 0; end
      m_vld = 1'b0;
    end else begin
      m_vld = rd_en;
      if (rd_en) begin
        m_rd_old = m_mem[rd_addr];
        m_rd_new = coll ? merge(m_mem[rd_addr], wr_data, wr_be) : m_mem[rd_addr];
      end
      if (wr_en) m_mem[wr_addr] = merge(m_mem[wr_addr], wr_data, wr_be);
    end
    c_vld = rd_en;
    if (rd_en) begin
      c_rd       = coll ? merge(c_mem[rd_addr], wr_data, wr_be) : c_mem[rd_addr];
      c_rd_known = coll ? (c_known[rd_addr] | wr_be) : c_known[rd_addr];
    end
    if (wr_en) begin
      c_mem[wr_addr]   = merge(c_mem[wr_addr], wr_data, wr_be);
      c_known[wr_addr] = c_known[wr_addr] | wr_be;
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_be = '0; rd_en = 1'b0; rd_addr = '0;
  endtask

  task automatic cycle();
    if (busy_n === 1'b1) busy_seen++;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [1:0] be);
    drive_idle(); wr_en = 1'b1; wr_addr = a; wr_data = d; wr_be = be;
    cycle(); drive_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a);
    drive_idle(); rd_en = 1'b1; rd_addr = a;
    cycle(); drive_idle();
  endtask

  task automatic wait_clear_done();
    for (int i = 0; i < 40; i++) begin
      if (busy_n !== 1'b1) break;
      cycle();
    end
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (rd_data_n !== 16'h0) $display("FAIL reset_rd_data: got %h want 0000", rd_data_n); else n_pass++;
    n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL reset_rd_valid: got %b want 0", rd_valid_n); else n_pass++;
    n_checks++; if (busy_n !== 1'b1) $display("FAIL reset_busy: got %b want 1", busy_n); else n_pass++;
    n_checks++; if (busy_c !== 1'b0) $display("FAIL reset_busy_noclear: got %b want 0", busy_c); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
  endtask

  // Requests thrown at the clearing builds while busy must be ignored.
  task automatic test_clear_busy();
    for (int i = 0; i < 40; i++) begin
      if (busy_n !== 1'b1) break;
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom_range(0, 15));
      wr_data = 16'($urandom); wr_be = 2'($urandom_range(0, 3));
      rd_en = 1'($urandom_range(0, 1)); rd_addr = 4'($urandom_range(0, 15));
      cycle();
      n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL busy_rd_valid: got %b want 0", rd_valid_n); else n_pass++;
      n_checks++; if (rd_valid_o !== 1'b0) $display("FAIL busy_rd_valid_old: got %b want 0", rd_valid_o); else n_pass++;
      n_checks++; if (busy_c !== 1'b0) $display("FAIL noclear_busy: got %b want 0", busy_c); else n_pass++;
      n_checks++; if (rd_valid_c !== c_vld) $display("FAIL noclear_rd_valid: got %b want %b", rd_valid_c, c_vld); else n_pass++;
    end
    drive_idle();
    n_checks++; if (busy_seen !== 16) $display("FAIL clear_len: got %0d cycles want 16", busy_seen); else n_pass++;
    n_checks++; if (busy_n !== 1'b0) $display("FAIL clear_done_busy: got %b want 0", busy_n); else n_pass++;
  endtask

  task automatic test_clear_read();
    logic [DW-1:0] e;
    for (int a = 0; a < DEPTH; a++) begin
      exp_q.push_back(16'h0000);
      do_read(4'(a));
      e = exp_q.pop_front();
      n_checks++; if (rd_data_n !== e) $display("FAIL clear_read[%0d]: got %h want %h", a, rd_data_n, e); else n_pass++;
      n_checks++; if (rd_data_o !== e) $display("FAIL clear_read_old[%0d]: got %h want %h", a, rd_data_o, e); else n_pass++;
      n_checks++; if (rd_valid_n !== 1'b1) $display("FAIL clear_read_valid[%0d]: got %b want 1", a, rd_valid_n); else n_pass++;
    end
    cycle();
    n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL idle_valid: got %b want 0", rd_valid_n); else n_pass++;
    n_checks++; if (rd_data_n !== 16'h0) $display("FAIL idle_hold: got %h want 0000", rd_data_n); else n_pass++;
  endtask

  task automatic test_byte_enable();
    do_write(4'd3, 16'h1234, 2'b11);
    do_write(4'd3, 16'hABCD, 2'b01);
    do_read(4'd3);
    n_checks++; if (rd_data_n !== 16'h12CD) $display("FAIL be_low: got %h want 12CD", rd_data_n); else n_pass++;
    do_write(4'd3, 16'h1234, 2'b11);
    do_write(4'd3, 16'hABCD, 2'b10);
    do_read(4'd3);
    n_checks++; if (rd_data_n !== 16'hAB34) $display("FAIL be_high: got %h want AB34", rd_data_n); else n_pass++;
    do_write(4'd3, 16'hFFFF, 2'b00);
    do_read(4'd3);
    n_checks++; if (rd_data_n !== 16'hAB34) $display("FAIL be_none: got %h want AB34", rd_data_n); else n_pass++;
    cycle();
    n_checks++; if (rd_data_n !== 16'hAB34) $display("FAIL rd_hold: got %h want AB34", rd_data_n); else n_pass++;
  endtask

  task automatic test_rdw();
    do_write(4'd5, 16'h1111, 2'b11);
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h2222; wr_be = 2'b11;
    rd_en = 1'b1; rd_addr = 4'd5;
    cycle(); drive_idle();
    n_checks++; if (rd_data_n !== 16'h2222) $display("FAIL rdw_new: got %h want 2222", rd_data_n); else n_pass++;
    n_checks++; if (rd_data_o !== 16'h1111) $display("FAIL rdw_old: got %h want 1111", rd_data_o); else n_pass++;
    n_checks++; if (rd_data_c !== 16'h2222) $display("FAIL rdw_noclear: got %h want 2222", rd_data_c); else n_pass++;
    do_read(4'd5);
    n_checks++; if (rd_data_n !== 16'h2222) $display("FAIL rdw_after_new: got %h want 2222", rd_data_n); else n_pass++;
    n_checks++; if (rd_data_o !== 16'h2222) $display("FAIL rdw_after_old: got %h want 2222", rd_data_o); else n_pass++;
  endtask

  // Random traffic, narrow address window part of the time to force collisions.
  task automatic test_random();
    logic [AW-1:0] hi;
    for (int i = 0; i < 400; i++) begin
      hi = (i % 2 == 0) ? 4'd3 : 4'd15;
      wr_en = 1'($urandom_range(0, 1)); wr_addr = 4'($urandom_range(0, hi));
      wr_data = 16'($urandom); wr_be = 2'($urandom_range(0, 3));
      rd_en = 1'($urandom_range(0, 1)); rd_addr = 4'($urandom_range(0, hi));
      cycle();
      n_checks++; if (rd_valid_n !== m_vld) $display("FAIL rand_valid[%0d]: got %b want %b", i, rd_valid_n, m_vld); else n_pass++;
      n_checks++; if (rd_data_n !== m_rd_new) $display("FAIL rand_new[%0d]: got %h want %h", i, rd_data_n, m_rd_new); else n_pass++;
      n_checks++; if (rd_data_o !== m_rd_old) $display("FAIL rand_old[%0d]: got %h want %h", i, rd_data_o, m_rd_old); else n_pass++;
      n_checks++; if (((rd_data_c ^ c_rd) & lane_mask(c_rd_known)) !== 16'h0)
        $display("FAIL rand_noclear[%0d]: got %h want %h (mask %h)", i, rd_data_c, c_rd, lane_mask(c_rd_known));
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_reset_mid_clear();
    logic [DW-1:0] v;
    do_write(4'd12, 16'hBEEF, 2'b11);
    do_read(4'd12);
    n_checks++; if (rd_data_n !== 16'hBEEF) $display("FAIL pre_reset_read: got %h want BEEF", rd_data_n); else n_pass++;
    rst_n = 1'b0; model_reset();
    #1;
    n_checks++; if (rd_data_n !== 16'h0) $display("FAIL async_rd_data: got %h want 0000", rd_data_n); else n_pass++;
    n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL async_rd_valid: got %b want 0", rd_valid_n); else n_pass++;
    n_checks++; if (busy_n !== 1'b1) $display("FAIL async_busy: got %b want 1", busy_n); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    // The no-clear build must accept traffic on the first edge after reset.
    v = 16'($urandom);
    do_write(4'd9, v, 2'b11);
    do_read(4'd9);
    n_checks++; if (rd_data_c !== v) $display("FAIL noclear_first_rw: got %h want %h", rd_data_c, v); else n_pass++;
    n_checks++; if (rd_valid_c !== 1'b1) $display("FAIL noclear_first_valid: got %b want 1", rd_valid_c); else n_pass++;
    n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL busy_ignore_read: got %b want 0", rd_valid_n); else n_pass++;
    repeat (5) cycle();
    n_checks++; if (busy_n !== 1'b1) $display("FAIL mid_clear_busy: got %b want 1", busy_n); else n_pass++;
    rst_n = 1'b0; model_reset();
    #1;
    n_checks++; if (rd_data_n !== 16'h0) $display("FAIL mid_rd_data: got %h want 0000", rd_data_n); else n_pass++;
    n_checks++; if (rd_valid_n !== 1'b0) $display("FAIL mid_rd_valid: got %b want 0", rd_valid_n); else n_pass++;
    n_checks++; if (rd_data_c !== 16'h0) $display("FAIL mid_rd_data_noclear: got %h want 0000", rd_data_c); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    wait_clear_done();
    n_checks++; if (busy_seen !== 16) $display("FAIL restart_len: got %0d cycles want 16", busy_seen); else n_pass++;
    do_read(4'd12);
    n_checks++; if (rd_data_n !== 16'h0) $display("FAIL restart_addr12: got %h want 0000", rd_data_n); else n_pass++;
    n_checks++; if (rd_data_o !== 16'h0) $display("FAIL restart_addr12_old: got %h want 0000", rd_data_o); else n_pass++;
    n_checks++; if (rd_data_c !== 16'hBEEF) $display("FAIL noclear_keeps: got %h want BEEF", rd_data_c); else n_pass++;
  endtask

  initial begin
    for (int a = 0; a < DEPTH; a++) begin
      m_mem[a] = 'x; c_mem[a] = '0; c_known[a] = 2'b00;
    end
    busy_seen = 0;
    test_reset();
    test_clear_busy();
    test_clear_read();
    test_byte_enable();
    test_rdw();
    test_random();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
